regfile_fp_param: RTL and testbench

REGFILE_FP_PARAM -- requirements
Module: regfile_fp_param

---
 rtl/regfile_fp_param.sv | 94 +++++++++
 tb/tb_regfile_fp_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_fp_param.sv
`default_nettype none
// regfile_fp_param: multi-port FP physical register file with sweep-clear after reset and per-register ready bits.
// Optional macro REGFILE_FP_BYPASS_EN forwards same-cycle writeback data and readiness to matching read ports.
module regfile_fp_param #(
  parameter int NUM_REGS = 64,
  parameter int DATA_W   = 64,
  parameter int NUM_WR   = 2,
  parameter int NUM_RD   = 3,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [NUM_WR-1:0]          write_enable_i,
  input  logic [NUM_WR*ADDR_W-1:0]   write_addr_i,
  input  logic [NUM_WR*DATA_W-1:0]   write_data_i,
  input  logic                       alloc_valid_i,
  input  logic [ADDR_W-1:0]          alloc_addr_i,
  input  logic [NUM_RD*ADDR_W-1:0]   read_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   read_data_o,
  output logic [NUM_RD-1:0]          read_ready_o,
  output logic                       init_done_o
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   init_cnt;
  logic                init_done;
  logic [NUM_REGS-1:0] ready;
  logic [DATA_W-1:0]   mem [NUM_REGS];

  // Alloc is applied after the writeback loop so it wins on a same-address collision.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      ready     <= '1;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + ADDR_W'(1);
          if (init_cnt == LAST_IDX) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          for (int i = 0; i < NUM_WR; i++) begin
            if (write_enable_i[i]) ready[write_addr_i[i*ADDR_W +: ADDR_W]] <= 1'b1;
          end
          if (alloc_valid_i) ready[alloc_addr_i] <= 1'b0;
        end
      endcase
    end
  end

  // Array contents are never reset; the INIT sweep clears them. Later ports override earlier ones.
  always_ff @(posedge clk_i) begin
    if (state == INIT) begin
      mem[init_cnt] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (write_enable_i[i]) mem[write_addr_i[i*ADDR_W +: ADDR_W]] <= write_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    read_data_o  = '0;
    read_ready_o = '1;
    if (state == RUN) begin
      for (int j = 0; j < NUM_RD; j++) begin
        read_data_o[j*DATA_W +: DATA_W] = mem[read_addr_i[j*ADDR_W +: ADDR_W]];
        read_ready_o[j]                 = ready[read_addr_i[j*ADDR_W +: ADDR_W]];
`ifdef REGFILE_FP_BYPASS_EN
        for (int i = 0; i < NUM_WR; i++) begin
          if (write_enable_i[i] &&
              (write_addr_i[i*ADDR_W +: ADDR_W] == read_addr_i[j*ADDR_W +: ADDR_W])) begin
            read_data_o[j*DATA_W +: DATA_W] = write_data_i[i*DATA_W +: DATA_W];
            read_ready_o[j]                 = 1'b1;
          end
        end
`endif
      end
    end
  end

  assign init_done_o = init_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_fp_param.sv
`default_nettype none
// tb_regfile_fp_param: randomized and directed checks of regfile_fp_param against an array-based reference model.
module tb_regfile_fp_param;

  localparam int NUM_REGS = 64;
  localparam int DATA_W   = 64;
  localparam int NUM_WR   = 2;
  localparam int NUM_RD   = 3;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_WR-1:0] we;
  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic              alloc;
  logic [ADDR_W-1:0] aa;
  logic [ADDR_W-1:0] ra [NUM_RD];

  logic [NUM_WR*ADDR_W-1:0] wa_flat;
  logic [NUM_WR*DATA_W-1:0] wd_flat;
  logic [NUM_RD*ADDR_W-1:0] ra_flat;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_ready;
  logic                     init_done;

  always_comb begin
    wa_flat = '0;
    wd_flat = '0;
    ra_flat = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      wa_flat[i*ADDR_W +: ADDR_W] = wa[i];
      wd_flat[i*DATA_W +: DATA_W] = wd[i];
    end
    for (int j = 0; j < NUM_RD; j++) ra_flat[j*ADDR_W +: ADDR_W] = ra[j];
  end

  regfile_fp_param #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .write_enable_i (we),
    .write_addr_i   (wa_flat),
    .write_data_i   (wd_flat),
    .alloc_valid_i  (alloc),
    .alloc_addr_i   (aa),
    .read_addr_i    (ra_flat),
    .read_data_o    (rd_data),
    .read_ready_o   (rd_ready),
    .init_done_o    (init_done)
  );

  // Reference model: register contents, ready bits and sweep progress.
  logic [DATA_W-1:0] m_mem [NUM_REGS];
  logic              m_rdy [NUM_REGS];
  logic              m_init;
  int                m_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1;
    m_cnt  = 0;
    for (int r = 0; r < NUM_REGS; r++) m_rdy[r] = 1'b1;
  endtask

  task automatic model_edge();
    if (!rstn) begin
      model_reset();
    end else if (m_init) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == NUM_REGS) m_init = 1'b0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (we[i]) begin
          m_mem[wa[i]] = wd[i];
          m_rdy[wa[i]] = 1'b1;
        end
      end
      if (alloc) m_rdy[aa] = 1'b0;
    end
  endtask

  function automatic logic [DATA_W:0] exp_read(int j);
    logic [DATA_W-1:0] d;
    logic              r;
    if (m_init) return {1'b1, {DATA_W{1'b0}}};
    d = m_mem[ra[j]];
    r = m_rdy[ra[j]];
`ifdef REGFILE_FP_BYPASS_EN
    for (int i = 0; i < NUM_WR; i++) begin
      if (we[i] && wa[i] == ra[j]) begin
        d = wd[i];
        r = 1'b1;
      end
    end
`endif
    return {r, d};
  endfunction

  task automatic compare_all();
    logic [DATA_W:0] e;
    check("init_done", 64'(init_done), 64'(!m_init));
    for (int j = 0; j < NUM_RD; j++) begin
      e = exp_read(j);
      check("rd_data", rd_data[j*DATA_W +: DATA_W], e[DATA_W-1:0]);
      check("rd_ready", 64'(rd_ready[j]), 64'(e[DATA_W]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    we    = '0;
    alloc = 1'b0;
    aa    = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      wa[i] = '0;
      wd[i] = '0;
    end
    for (int j = 0; j < NUM_RD; j++) ra[j] = '0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NUM_WR; i++) begin
      we[i] = 1'($urandom_range(0, 1));
      wa[i] = ADDR_W'($urandom_range(0, 15));
      wd[i] = {$urandom, $urandom};
    end
    alloc = ($urandom_range(0, 3) == 0);
    aa    = ADDR_W'($urandom_range(0, 15));
    for (int j = 0; j < NUM_RD; j++) ra[j] = ADDR_W'($urandom_range(0, 15));
  endtask

  // Called one step after rstn releases; traffic during the sweep must be ignored.
  task automatic init_window();
    for (int k = 0; k <= NUM_REGS; k++) begin
      rand_inputs();
      if (k == 10) begin
        we[0] = 1'b1; wa[0] = 6'd5; wd[0] = 64'hDEAD;
      end
      if (k == NUM_REGS) clear_inputs();
      @(negedge clk);
      check("done_timing", 64'(init_done), 64'(k >= NUM_REGS));
      compare_all();
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic sweep_check();
    clear_inputs();
    for (int r = 0; r < NUM_REGS; r += NUM_RD) begin
      for (int j = 0; j < NUM_RD; j++) ra[j] = ADDR_W'((r + j) % NUM_REGS);
      #1;
      for (int j = 0; j < NUM_RD; j++) begin
        check("sweep_zero", rd_data[j*DATA_W +: DATA_W], 64'h0);
        check("sweep_ready", 64'(rd_ready[j]), 64'h1);
      end
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (3) tick();
    check("rst_done", 64'(init_done), 64'h0);
    check("rst_ready", 64'(rd_ready), 64'h7);
    rstn = 1'b1;
    init_window();
    sweep_check();
    ra[0] = 6'd5;
    #1;
    check("init_write_ignored", rd_data[0 +: DATA_W], 64'h0);

    clear_inputs();
    we = 2'b11; wa[0] = 6'd7; wa[1] = 6'd7; wd[0] = 64'h1111; wd[1] = 64'h2222;
    tick();
    clear_inputs();
    ra[1] = 6'd7;
    #1;
    check("dual_write", rd_data[DATA_W +: DATA_W], 64'h2222);

    clear_inputs();
    alloc = 1'b1; aa = 6'd9; we[1] = 1'b1; wa[1] = 6'd9; wd[1] = 64'hABCD;
    tick();
    clear_inputs();
    ra[2] = 6'd9;
    #1;
    check("alloc_ready", 64'(rd_ready[2]), 64'h0);
    check("alloc_data", rd_data[2*DATA_W +: DATA_W], 64'hABCD);

    clear_inputs();
    we[0] = 1'b1; wa[0] = 6'd3; wd[0] = 64'h5;
    tick();
    clear_inputs();
    we[0] = 1'b1; wa[0] = 6'd3; wd[0] = 64'h77; ra[0] = 6'd3;
    #1;
`ifdef REGFILE_FP_BYPASS_EN
    check("bypass_same", rd_data[0 +: DATA_W], 64'h77);
`else
    check("bypass_same", rd_data[0 +: DATA_W], 64'h5);
`endif
    tick();
    clear_inputs();
    ra[0] = 6'd3;
    #1;
    check("bypass_next", rd_data[0 +: DATA_W], 64'h77);

    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      tick();
    end

    clear_inputs();
    rstn = 1'b0;
    #1;
    model_reset();
    check("midrst_done", 64'(init_done), 64'h0);
    check("midrst_ready", 64'(rd_ready), 64'h7);
    tick();
    rstn = 1'b1;
    init_window();
    sweep_check();

    for (int n = 0; n < 200; n++) begin
      rand_inputs();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
